thresholding_cfg_axilite: RTL

- Bridges an AXI4-Lite slave port onto the threshold configuration interface (cfg_en/cfg_we/cfg_a/cfg_d/cfg_rack/cfg_q) of the binary-search thresholding core.
- Sits directly upstream of the core's configuration port.
- Serialises AXI reads and writes into single-cycle config ops, waits for the core's delayed readback acknowledge, and returns AXI responses.
- Only one operation is outstanding at a time.

---
 rtl/thresholding_pkg.sv | 16 +
 rtl/thresholding_cfg_axilite.sv | 108 ++++++++++
 2 files changed

// File: rtl/thresholding_pkg.sv
// Shared definitions for the thresholding core configuration bridge:
// controller state encoding and the AXI response code.
package thresholding_pkg;

  typedef logic [2:0] cfg_state_e;

  localparam cfg_state_e IDLE     = 3'd0;
  localparam cfg_state_e WR_ISSUE = 3'd1;
  localparam cfg_state_e WR_RESP  = 3'd2;
  localparam cfg_state_e RD_ISSUE = 3'd3;
  localparam cfg_state_e RD_WAIT  = 3'd4;
  localparam cfg_state_e RD_RESP  = 3'd5;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/thresholding_cfg_axilite.sv
// AXI4-Lite slave that turns reads and writes into single-cycle threshold
// configuration ops on the core, one operation outstanding at a time.
module thresholding_cfg_axilite
  import thresholding_pkg::*;
#(
  parameter int N  = 4,
  parameter int K  = 16,
  parameter int C  = 1,
  parameter int PE = 1,
  localparam int CF        = C / PE,
  localparam int CFG_BITS  = $clog2(CF) + $clog2(PE) + N,
  localparam int ADDR_BITS = CFG_BITS + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_axilite_awvalid,
  output logic                 s_axilite_awready,
  input  logic [ADDR_BITS-1:0] s_axilite_awaddr,
  input  logic                 s_axilite_wvalid,
  output logic                 s_axilite_wready,
  input  logic [31:0]          s_axilite_wdata,
  input  logic [3:0]           s_axilite_wstrb,
  output logic                 s_axilite_bvalid,
  input  logic                 s_axilite_bready,
  output logic [1:0]           s_axilite_bresp,
  input  logic                 s_axilite_arvalid,
  output logic                 s_axilite_arready,
  input  logic [ADDR_BITS-1:0] s_axilite_araddr,
  output logic                 s_axilite_rvalid,
  input  logic                 s_axilite_rready,
  output logic [31:0]          s_axilite_rdata,
  output logic [1:0]           s_axilite_rresp,
  output logic                 cfg_en,
  output logic                 cfg_we,
  output logic [CFG_BITS-1:0]  cfg_a,
  output logic [K-1:0]         cfg_d,
  input  logic                 cfg_rack,
  input  logic [K-1:0]         cfg_q
);

  cfg_state_e state;
  logic       last_was_write;
  logic       wr_cand;
  logic       rd_cand;
  logic       grant_wr;
  logic       grant_rd;
  logic       unused_bits;

  assign wr_cand = s_axilite_awvalid && s_axilite_wvalid;
  assign rd_cand = s_axilite_arvalid;

  // On a conflict the flag remembers which type won the previous conflict so the
  // other type goes next; lone requests win without touching it.
  assign grant_wr = (state == IDLE) && wr_cand && (!rd_cand || !last_was_write);
  assign grant_rd = (state == IDLE) && rd_cand && (!wr_cand || last_was_write);

  assign s_axilite_awready = grant_wr;
  assign s_axilite_wready  = grant_wr;
  assign s_axilite_arready = grant_rd;
  assign s_axilite_bvalid  = (state == WR_RESP);
  assign s_axilite_rvalid  = (state == RD_RESP);
  assign s_axilite_bresp   = RESP_OKAY;
  assign s_axilite_rresp   = RESP_OKAY;
  assign cfg_en            = (state == WR_ISSUE) || (state == RD_ISSUE);

  assign unused_bits = ^{s_axilite_wstrb, s_axilite_awaddr, s_axilite_araddr, s_axilite_wdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      last_was_write  <= 1'b0;
      cfg_we          <= 1'b0;
      cfg_a           <= '0;
      cfg_d           <= '0;
      s_axilite_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_wr) begin
            cfg_a  <= s_axilite_awaddr[ADDR_BITS-1:2];
            cfg_d  <= s_axilite_wdata[K-1:0];
            cfg_we <= 1'b1;
            state  <= WR_ISSUE;
            if (rd_cand) last_was_write <= 1'b1;
          end else if (grant_rd) begin
            cfg_a  <= s_axilite_araddr[ADDR_BITS-1:2];
            cfg_we <= 1'b0;
            state  <= RD_ISSUE;
            if (wr_cand) last_was_write <= 1'b0;
          end
        end
        WR_ISSUE: state <= WR_RESP;
        WR_RESP:  if (s_axilite_bready) state <= IDLE;
        RD_ISSUE: state <= RD_WAIT;
        // Racks outside this state belong to nothing we are waiting for.
        RD_WAIT: begin
          if (cfg_rack) begin
            s_axilite_rdata <= 32'(cfg_q);
            state           <= RD_RESP;
          end
        end
        RD_RESP:  if (s_axilite_rready) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule
